// File: rtl/bfm_apbtoahb_pkg.sv
// Shared definitions for the APB3-completer to AHB-Lite-initiator BFM bridge:
// AHB transfer encodings, FSM state encoding and the APB address-mask helper.
`timescale 1ns/1ps
package bfm_apbtoahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Ones in the bit positions taken from PADDR; the rest come from AHB_BASE.
    function automatic logic [31:0] addr_low_mask(input int w);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++)
            if (i < w) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/bfm_apbtoahb.sv
// APB3 completer that turns each APB access into one NONSEQ single-word
// AHB-Lite transfer; the APB access completes once the AHB data phase ends.
`timescale 1ns/1ps
module bfm_apbtoahb
    import bfm_apbtoahb_pkg::*;
#(
    parameter int          TPD            = 1,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter logic [31:0] AHB_BASE       = 32'h0000_0000,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [31:0] LOW_MASK = addr_low_mask(APB_ADDR_WIDTH);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, hwdata_q, prdata_q;
    logic        write_q, pready_q, pslverr_q;
    logic [31:0] setup_addr;

    // Word-aligned: PADDR[1:0] never reaches the AHB side.
    assign setup_addr = ((AHB_BASE & ~LOW_MASK) | (PADDR & LOW_MASK)) & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (PSEL && !PENABLE) state_d = ST_ADDR;
            ST_ADDR: if (HREADY)           state_d = ST_DATA;
            ST_DATA: if (HREADY)           state_d = ST_RESP;
            ST_RESP:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            hwdata_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: if (PSEL && !PENABLE) begin
                    addr_q  <= setup_addr;
                    write_q <= PWRITE;
                    wdata_q <= PWDATA;
                end
                ST_ADDR: if (HREADY) hwdata_q <= wdata_q;
                // First ERROR cycle has HREADY=0, so only the final cycle is sampled.
                ST_DATA: if (HREADY) begin
                    if (!write_q) prdata_q <= HRDATA;
                    pslverr_q <= HRESP;
                    pready_q  <= 1'b1;
                end
                ST_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign #(TPD) HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign #(TPD) HADDR     = addr_q;
    assign #(TPD) HWRITE    = write_q;
    assign #(TPD) HWDATA    = hwdata_q;
    assign #(TPD) HSIZE     = HSIZE_WORD;
    assign #(TPD) HBURST    = HBURST_SINGLE;
    assign #(TPD) HPROT     = HPROT_VAL;
    assign #(TPD) HMASTLOCK = 1'b0;
    assign #(TPD) PRDATA    = prdata_q;
    assign #(TPD) PREADY    = pready_q;
    assign #(TPD) PSLVERR   = pslverr_q;

endmodule

// File: tb/tb_bfm_apbtoahb.sv
// Self-checking bench: an APB master plus a scripted AHB slave, checked cycle by
// cycle against the access timeline derived from the bridge's latency rules.
`timescale 1ns/1ps
module tb_bfm_apbtoahb;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, HRDATA;
    logic        HREADY, HRESP;
    logic [31:0] PRDATA, HADDR, HWDATA;
    logic        PREADY, PSLVERR, HWRITE, HMASTLOCK;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    // Second instance with a 16-bit APB window, sharing all inputs.
    logic [31:0] PRDATA2, HADDR2, HWDATA2;
    logic        PREADY2, PSLVERR2, HWRITE2, HMASTLOCK2;
    logic [1:0]  HTRANS2;
    logic [2:0]  HSIZE2, HBURST2;
    logic [3:0]  HPROT2;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_prdata = '0;

    always #5 HCLK = ~HCLK;

    bfm_apbtoahb dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    bfm_apbtoahb #(.APB_ADDR_WIDTH(16), .AHB_BASE(32'h4000_0000)) dut16 (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA2),
        .PREADY(PREADY2), .PSLVERR(PSLVERR2), .HADDR(HADDR2), .HTRANS(HTRANS2),
        .HWRITE(HWRITE2), .HSIZE(HSIZE2), .HBURST(HBURST2), .HPROT(HPROT2),
        .HMASTLOCK(HMASTLOCK2), .HWDATA(HWDATA2), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    // One APB access. aw = AHB wait cycles in the address phase, dw = in the
    // data phase; err makes the last data wait the first ERROR cycle.
    task automatic do_access(input string name, input logic wr, input logic [31:0] paddr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int aw, input int dw, input logic err, input logic drop);
        int          last, ns_obs, rdy_obs;
        logic [31:0] exp_haddr, exp_haddr16;
        logic        in_addr, in_data;
        last        = aw + dw + 3;
        ns_obs      = 0;
        rdy_obs     = 0;
        exp_haddr   = {paddr[31:2], 2'b00};
        exp_haddr16 = {16'h4000, paddr[15:2], 2'b00};

        @(posedge HCLK); #2;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = paddr; PWDATA = wdata;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            failures++;
            $display("FAIL %s setup: HTRANS=%b PREADY=%b PSLVERR=%b, want 00 0 0",
                     name, HTRANS, PREADY, PSLVERR);
        end

        for (int k = 1; k <= last; k++) begin
            @(posedge HCLK); #2;
            PENABLE = 1'b1;
            PSEL    = !(drop && k >= 2);
            HRESP   = 1'b0;
            HRDATA  = $urandom;
            if (k <= aw)               HREADY = 1'b0;
            else if (k == aw + 1)      HREADY = 1'b1;
            else if (k <= aw + 1 + dw) begin HREADY = 1'b0; HRESP = err && (k == aw + 1 + dw); end
            else if (k == aw + 2 + dw) begin HREADY = 1'b1; HRESP = err; HRDATA = rdata; end
            else                       HREADY = 1'b1;
            if (drop && k == 2) $display("note: %s PSEL dropped mid-transfer (APB protocol violation)", name);
            @(negedge HCLK);
            in_addr = (k <= aw + 1);
            in_data = (k >= aw + 2) && (k <= aw + 2 + dw);
            if (HTRANS === 2'b10) ns_obs++;
            if (PREADY === 1'b1)  rdy_obs++;
            checks++;
            if (HTRANS !== (in_addr ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL %s htrans cycle %0d: got %b want %b", name, k, HTRANS, in_addr ? 2'b10 : 2'b00);
            end
            if (in_addr) begin
                checks++;
                if (HADDR !== exp_haddr || HWRITE !== wr || HADDR2 !== exp_haddr16) begin
                    failures++;
                    $display("FAIL %s addr cycle %0d: HADDR=%h HWRITE=%b HADDR16=%h, want %h %b %h",
                             name, k, HADDR, HWRITE, HADDR2, exp_haddr, wr, exp_haddr16);
                end
            end
            if (in_data) begin
                checks++;
                if (HWDATA !== wdata) begin
                    failures++;
                    $display("FAIL %s hwdata cycle %0d: got %h want %h", name, k, HWDATA, wdata);
                end
            end
            checks++;
            if (PREADY !== (k == last)) begin
                failures++;
                $display("FAIL %s pready cycle %0d: got %b want %b", name, k, PREADY, k == last);
            end
        end

        if (!wr) model_prdata = rdata;
        checks++;
        if (PSLVERR !== err || PRDATA !== model_prdata) begin
            failures++;
            $display("FAIL %s response: PSLVERR=%b PRDATA=%h, want %b %h",
                     name, PSLVERR, PRDATA, err, model_prdata);
        end
        checks++;
        if (ns_obs != aw + 1 || rdy_obs != 1) begin
            failures++;
            $display("FAIL %s counts: nonseq=%0d pready=%0d, want %0d 1", name, ns_obs, rdy_obs, aw + 1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #2;
            PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
            @(negedge HCLK);
            checks++;
            if (HTRANS !== 2'b00 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
                failures++;
                $display("FAIL idle: HTRANS=%b PREADY=%b PSLVERR=%b, want 00 0 0", HTRANS, PREADY, PSLVERR);
            end
        end
    endtask

    task automatic test_reset();
        HRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 32'h0 || PRDATA !== 32'h0 ||
            HWRITE !== 1'b0 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: HTRANS=%b HADDR=%h HWDATA=%h PRDATA=%h HWRITE=%b PREADY=%b PSLVERR=%b, want all 0",
                     HTRANS, HADDR, HWDATA, PRDATA, HWRITE, PREADY, PSLVERR);
        end
        checks++;
        if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
            failures++;
            $display("FAIL constants: HSIZE=%b HBURST=%b HPROT=%b HMASTLOCK=%b, want 010 000 0011 0",
                     HSIZE, HBURST, HPROT, HMASTLOCK);
        end
        @(posedge HCLK); #3;
        HRESETN = 1'b1;
    endtask

    task automatic test_random(input int n);
        logic wr, err;
        int   aw, dw;
        for (int i = 0; i < n; i++) begin
            wr  = 1'($urandom_range(0, 1));
            err = ($urandom_range(0, 3) == 0);
            aw  = $urandom_range(0, 3);
            dw  = $urandom_range(err ? 1 : 0, 3);
            do_access("random", wr, $urandom, $urandom, $urandom, aw, dw, err, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge HCLK); #2;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0000_0ABC; PWDATA = 32'hCAFE_F00D;
        HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #2;
        PENABLE = 1'b1;
        @(posedge HCLK); #2;
        HREADY = 1'b0;
        @(negedge HCLK); #1;
        HRESETN = 1'b0;
        #2;
        model_prdata = '0;
        checks++;
        if (HTRANS !== 2'b00 || PREADY !== 1'b0 || PRDATA !== 32'h0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: HTRANS=%b PREADY=%b PRDATA=%h HADDR=%h HWDATA=%h, want 00 0 0 0 0",
                     HTRANS, PREADY, PRDATA, HADDR, HWDATA);
        end
        PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
        @(posedge HCLK); #3;
        HRESETN = 1'b1;
        do_access("after_reset", 1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        idle_cycles(1);
        do_access("write_basic", 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 1'b0, 1'b0);
        idle_cycles(1);
        do_access("read_waits", 1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 2, 1'b0, 1'b0);
        idle_cycles(1);
        do_access("write_error", 1'b1, 32'h0000_0010, 32'h0F0F_0F0F, 32'h0, 0, 1, 1'b1, 1'b0);
        do_access("after_error", 1'b1, 32'h0000_0014, 32'h1111_2222, 32'h0, 0, 0, 1'b0, 1'b0);
        do_access("addr16", 1'b0, 32'hFFFF_1237, 32'h0, 32'h8765_4321, 0, 0, 1'b0, 1'b0);
        do_access("b2b_read", 1'b0, 32'h0000_0400, 32'h0, 32'hA5A5_5A5A, 3, 0, 1'b0, 1'b0);
        do_access("b2b_write", 1'b1, 32'h0000_0408, 32'h3C3C_C3C3, 32'h0, 3, 1, 1'b0, 1'b0);
        test_random(20);
        do_access("psel_drop", 1'b0, 32'h0000_0500, 32'h0, 32'h7777_1111, 1, 1, 1'b0, 1'b1);
        idle_cycles(2);
        test_reset_mid();
        idle_cycles(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
